// File: rtl/sr_drv_pkg.sv
// Shared op-codes, FSM state encoding and S/R drive helper for the SR command driver.
package sr_drv_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_RESETQ = 2'b01;
    localparam logic [1:0] OP_SETQ   = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    // {S,R} pattern that moves the flip-flop towards target; never 2'b11.
    function automatic logic [1:0] sr_drive(input logic target);
        return target ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// WAIT-cycle counter: counts enabled cycles and flags the TIMEOUT-th one.
module sr_drv_timer
    import sr_drv_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // NOTE: default assignment first so every path drives cnt_d; no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the TIMEOUT-th enabled cycle, so the caller leaves on that edge.
    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/sr_cmd_driver.sv
// Drives an external SR flip-flop from set/reset/toggle commands and checks the Q/Q_bar feedback.
// Optional saturating ok/err counters are built when SR_DRV_STATUS_CNT_EN is defined.
module sr_cmd_driver
    import sr_drv_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    output logic             req_ready,
    output logic             S,
    output logic             R,
    input  logic             Q,
    input  logic             Q_bar,
    output logic             done,
    output logic             err
`ifdef SR_DRV_STATUS_CNT_EN
    ,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    if (TIMEOUT < 1 || TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
        $error("sr_cmd_driver: TIMEOUT must be 1..255 and CNT_W at least 1");
    end

    state_e state_q, state_d;
    logic   target_q, target_d;
    logic   s_q, s_d;
    logic   r_q, r_d;
    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   accept;
    logic   tmr_expire;

`ifdef SR_DRV_STATUS_CNT_EN
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    assign accept = req_valid && (state_q == IDLE);

    sr_drv_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .Clk    (Clk),
        .Rst    (Rst),
        .clr    (state_q != WAIT),
        .en     (state_q == WAIT),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        s_d      = 1'b0;
        r_d      = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_op == OP_NOP) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                    end else begin
                        unique case (req_op)
                            OP_RESETQ: target_d = 1'b0;
                            OP_SETQ:   target_d = 1'b1;
                            default:   target_d = ~Q;
                        endcase
                        {s_d, r_d} = sr_drive(target_d);
                        state_d    = DRIVE;
                    end
                end
            end
            DRIVE: state_d = WAIT;
            WAIT: begin
                // Illegal feedback wins over a match; a match wins over the timeout.
                if (Q == Q_bar) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (Q == target_q) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                end else if (tmr_expire) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SR_DRV_STATUS_CNT_EN
    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (done_d && (ok_cnt_q != '1)) begin
            ok_cnt_d = ok_cnt_q + 1'b1;
        end
        if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            target_q  <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef SR_DRV_STATUS_CNT_EN
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef SR_DRV_STATUS_CNT_EN
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign S         = s_q;
    assign R         = r_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef SR_DRV_STATUS_CNT_EN
    assign ok_cnt  = ok_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule
